// File: rtl/sdram_rd_responder.sv
// Device-side SDRAM read responder: decodes ACTIVE/READ/BURST_STOP/PRECHARGE,
// tracks open rows per bank, streams full-page bursts from a sync memory with exact CAS latency.
module sdram_rd_responder #(
  parameter int CL    = 3,
  parameter int TRCD  = 2,
  parameter int ROW_W = 13,
  parameter int COL_W = 9
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst_n,
  input  logic [3:0]               sd_cmd,
  input  logic [1:0]               sd_bank,
  input  logic [ROW_W-1:0]         sd_addr,
  output logic                     mem_rd_en,
  output logic [ROW_W+COL_W+1:0]   mem_addr,
  input  logic [15:0]              mem_rdata,
  output logic [15:0]              dq,
  output logic                     dq_valid,
  output logic [2:0]               err
);

  localparam int AW = 2 + ROW_W + COL_W;
  localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;

  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  typedef enum logic {B_IDLE, B_BURST} bst_t;

  logic [3:0]       open_q, open_d;
  logic [ROW_W-1:0] row_q  [4];
  logic [ROW_W-1:0] row_d  [4];
  logic [TW-1:0]    trcd_q [4];
  logic [TW-1:0]    trcd_d [4];
  bst_t             state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       bbank_q, bbank_d;
  logic [ROW_W-1:0] brow_q, brow_d;
  logic             mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [2:0]       err_q, err_d;
  logic             rdata_vld_q;

  logic             is_act, is_rd, is_bst, is_pre, rd_ok, issue;
  logic [1:0]       iss_bank;
  logic [ROW_W-1:0] iss_row;
  logic [COL_W-1:0] iss_col;
  logic             dq_vld_w;
  logic [15:0]      dq_dat_w;

  always_comb begin
    is_act      = (sd_cmd == CMD_ACT);
    is_rd       = (sd_cmd == CMD_RD);
    is_bst      = (sd_cmd == CMD_BST);
    is_pre      = (sd_cmd == CMD_PRE);
    open_d      = open_q;
    row_d       = row_q;
    trcd_d      = trcd_q;
    err_d       = err_q;
    state_d     = state_q;
    col_d       = col_q;
    bbank_d     = bbank_q;
    brow_d      = brow_q;
    mem_addr_d  = mem_addr_q;
    issue       = 1'b0;
    iss_bank    = bbank_q;
    iss_row     = brow_q;
    iss_col     = col_q;

    for (int i = 0; i < 4; i++) begin
      if (trcd_q[i] != '0) trcd_d[i] = trcd_q[i] - TW'(1);
    end

    rd_ok = is_rd && open_q[sd_bank] && (trcd_q[sd_bank] == '0);

    if (is_act) begin
      if (open_q[sd_bank]) begin
        err_d[2] = 1'b1;
      end else begin
        open_d[sd_bank] = 1'b1;
        row_d[sd_bank]  = sd_addr;
        trcd_d[sd_bank] = TW'(TRCD - 1);
      end
    end

    if (is_rd && !open_q[sd_bank])  err_d[0] = 1'b1;
    else if (is_rd && !rd_ok)       err_d[1] = 1'b1;

    if (is_pre) begin
      if (sd_addr[10]) open_d = '0;
      else             open_d[sd_bank] = 1'b0;
    end

    // An accepted READ always wins: it starts or restarts the burst on this same edge.
    if (rd_ok) begin
      state_d  = B_BURST;
      bbank_d  = sd_bank;
      brow_d   = row_q[sd_bank];
      iss_bank = sd_bank;
      iss_row  = row_q[sd_bank];
      iss_col  = sd_addr[COL_W-1:0];
      issue    = 1'b1;
    end else if (state_q == B_BURST) begin
      if (is_bst || is_pre) state_d = B_IDLE;
      else                  issue   = 1'b1;
    end

    mem_rd_en_d = issue;
    if (issue) begin
      col_d      = iss_col + COL_W'(1);
      mem_addr_d = {iss_bank, iss_row, iss_col};
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      open_q <= '0;
      for (int i = 0; i < 4; i++) begin
        row_q[i]  <= '0;
        trcd_q[i] <= '0;
      end
      state_q     <= B_IDLE;
      col_q       <= '0;
      bbank_q     <= '0;
      brow_q      <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      err_q       <= '0;
      rdata_vld_q <= 1'b0;
    end else begin
      open_q      <= open_d;
      row_q       <= row_d;
      trcd_q      <= trcd_d;
      state_q     <= state_d;
      col_q       <= col_d;
      bbank_q     <= bbank_d;
      brow_q      <= brow_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      err_q       <= err_d;
      rdata_vld_q <= mem_rd_en_q;
    end
  end

  // mem_rdata arrives one cycle after the strobe; CL-2 further stages align it to CAS latency.
  generate
    if (CL == 2) begin : g_cl2
      assign dq_vld_w = rdata_vld_q;
      assign dq_dat_w = mem_rdata;
    end else begin : g_pipe
      logic [CL-3:0] pvld_q;
      logic [15:0]   pdat_q [CL-2];
      always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
          pvld_q <= '0;
          for (int i = 0; i < CL - 2; i++) pdat_q[i] <= '0;
        end else begin
          pvld_q[0] <= rdata_vld_q;
          pdat_q[0] <= mem_rdata;
          for (int i = 1; i < CL - 2; i++) begin
            pvld_q[i] <= pvld_q[i-1];
            pdat_q[i] <= pdat_q[i-1];
          end
        end
      end
      assign dq_vld_w = pvld_q[CL-3];
      assign dq_dat_w = pdat_q[CL-3];
    end
  endgenerate

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign err       = err_q;
  assign dq_valid  = dq_vld_w;
  assign dq        = dq_vld_w ? dq_dat_w : 16'h0000;

endmodule

// File: tb/tb_sdram_rd_responder.sv
// Directed bench for sdram_rd_responder: scoreboard of expected issue addresses and
// CAS-aligned read data, plus error-flag and reset checks.
module tb_sdram_rd_responder;

  localparam int CL   = 3;
  localparam int TRCD = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;

  logic        rd_clk    = 1'b0;
  logic        rd_rst_n  = 1'b1;
  logic [3:0]  sd_cmd    = NOP;
  logic [1:0]  sd_bank   = 2'd0;
  logic [12:0] sd_addr   = 13'd0;
  logic        mem_rd_en;
  logic [23:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] dq;
  logic        dq_valid;
  logic [2:0]  err;

  typedef struct {
    int          e;
    logic [23:0] a;
  } ent_t;

  ent_t aq[$];
  ent_t dqq[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;

  sdram_rd_responder #(.CL(CL), .TRCD(TRCD), .ROW_W(13), .COL_W(9)) dut (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .sd_cmd    (sd_cmd),
    .sd_bank   (sd_bank),
    .sd_addr   (sd_addr),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dq        (dq),
    .dq_valid  (dq_valid),
    .err       (err)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [15:0] f(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h3C5A;
  endfunction

  // Backing memory: data for the strobed address appears the cycle after the strobe.
  always @(posedge rd_clk) mem_rdata <= mem_rd_en ? f(mem_addr) : 16'hDEAD;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : monitor
    ent_t x;
    forever begin
      @(posedge rd_clk);
      ecnt++;
      #1;
      if (mem_rd_en) begin
        chk(32'(aq.size() > 0), 32'd1, "unexpected_issue");
        if (aq.size() > 0) begin
          x = aq.pop_front();
          chk(32'(mem_addr), 32'(x.a), "issue_addr");
          chk(32'(ecnt), 32'(x.e), "issue_edge");
        end
      end else if (aq.size() > 0 && aq[0].e <= ecnt) begin
        chk(32'(mem_rd_en), 32'd1, "missing_issue");
        void'(aq.pop_front());
      end
      if (dq_valid) begin
        chk(32'(dqq.size() > 0), 32'd1, "unexpected_dq");
        if (dqq.size() > 0) begin
          x = dqq.pop_front();
          chk(32'(dq), 32'(f(x.a)), "dq_data");
          chk(32'(ecnt), 32'(x.e + CL - 1), "dq_edge");
        end
      end else begin
        chk(32'(dq), 32'd0, "dq_idle_zero");
        if (dqq.size() > 0 && dqq[0].e + CL - 1 <= ecnt) begin
          chk(32'(dq_valid), 32'd1, "missing_dq");
          void'(dqq.pop_front());
        end
      end
    end
  end

  // Each drive occupies exactly one sampling edge; the bus returns to NOP afterwards.
  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    @(negedge rd_clk);
    sd_cmd  = c;
    sd_bank = b;
    sd_addr = a;
    @(posedge rd_clk);
    #2;
    sd_cmd  = NOP;
  endtask

  task automatic nop(input int n);
    repeat (n) drive(NOP, 2'd0, 13'd0);
  endtask

  task automatic rd_burst(input logic [1:0] b, input logic [12:0] row, input logic [8:0] col,
                          input int n);
    int k;
    k = ecnt + 1;
    for (int i = 0; i < n; i++) begin
      ent_t x;
      logic [8:0] c;
      c   = col + 9'(i);
      x.e = k + i;
      x.a = {b, row, c};
      aq.push_back(x);
      dqq.push_back(x);
    end
    drive(RD, b, {4'd0, col});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 16 && (aq.size() > 0 || dqq.size() > 0); i++) nop(1);
    chk(32'(aq.size() + dqq.size()), 32'd0, tag);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    #1 rd_rst_n = 1'b0;
    #20;
    chk(32'(mem_rd_en), 32'd0, "rst_mem_rd_en");
    chk(32'(mem_addr),  32'd0, "rst_mem_addr");
    chk(32'(dq),        32'd0, "rst_dq");
    chk(32'(dq_valid),  32'd0, "rst_dq_valid");
    chk(32'(err),       32'd0, "rst_err");
    @(negedge rd_clk);
    rd_rst_n = 1'b1;

    // 8-word burst on bank 1, row 0x123, col 0x010
    drive(ACT, 2'd1, 13'h0123);
    nop(1);
    rd_burst(2'd1, 13'h0123, 9'h010, 8);
    nop(7);
    drive(BST, 2'd0, 13'd0);
    drain("drain_burst8");
    chk(32'(err), 32'd0, "err_after_burst8");

    // column wrap within the page
    rd_burst(2'd1, 13'h0123, 9'h1FE, 4);
    nop(3);
    drive(BST, 2'd0, 13'd0);
    drain("drain_wrap");

    // tRCD violation, then legal retry
    drive(ACT, 2'd0, 13'h00AA);
    drive(RD, 2'd0, 13'h0005);
    chk(32'(err), 32'b010, "err_trcd");
    rd_burst(2'd0, 13'h00AA, 9'h005, 2);
    nop(1);
    drive(BST, 2'd0, 13'd0);
    drain("drain_trcd_retry");

    // ACTIVE to another bank mid-burst, then PRECHARGE all ends it
    rd_burst(2'd0, 13'h00AA, 9'h040, 4);
    nop(1);
    drive(ACT, 2'd3, 13'h1555);
    nop(1);
    drive(PRE, 2'd0, 13'h0400);
    drain("drain_precharge");
    chk(32'(err), 32'b010, "err_act_other_bank");
    drive(RD, 2'd2, 13'h0000);
    chk(32'(err), 32'b011, "err_read_closed");
    drive(ACT, 2'd2, 13'h0777);
    chk(32'(err), 32'b011, "err_act_after_pre");

    // double ACTIVE keeps the first row; READ restart and rejected READ mid-burst
    drive(ACT, 2'd3, 13'h0321);
    drive(ACT, 2'd3, 13'h1ABC);
    chk(32'(err), 32'b111, "err_double_act");
    nop(1);
    rd_burst(2'd3, 13'h0321, 9'h000, 2);
    nop(1);
    rd_burst(2'd2, 13'h0777, 9'h100, 4);
    nop(1);
    drive(RD, 2'd1, 13'h0007);
    nop(1);
    drive(BST, 2'd0, 13'd0);
    drain("drain_restart");

    // reset mid-burst drops in-flight words immediately
    rd_burst(2'd2, 13'h0777, 9'h020, 4);
    nop(3);
    @(negedge rd_clk);
    rd_rst_n = 1'b0;
    #1;
    chk(32'(dq),        32'd0, "midrst_dq");
    chk(32'(dq_valid),  32'd0, "midrst_dq_valid");
    chk(32'(mem_rd_en), 32'd0, "midrst_mem_rd_en");
    chk(32'(aq.size()), 32'd0, "midrst_issue_count");
    dqq.delete();
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;
    chk(32'(err), 32'd0, "err_after_reset");
    drive(RD, 2'd0, 13'h0000);
    chk(32'(err), 32'b001, "err_read_after_reset");
    nop(4);
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
